// File: rtl/i2s_tdm_rx.sv
// I2S / TDM serial-audio receiver: captures NUM_CH slots per frame in the bit-clock domain,
// checks frame length against ws, and publishes a complete frame with a one-cycle strobe.
module i2s_tdm_rx #(
   parameter int WIDTH     = 16,
   parameter int SLOT_BITS = 32,
   parameter int NUM_CH    = 2,
   parameter int MODE      = 0
) (
   input  logic                     sclk_i,
   input  logic                     rst_i,
   input  logic                     ws_i,
   input  logic                     sdata_i,
   input  logic                     clrErr_i,
   output logic [NUM_CH*WIDTH-1:0]  chanData_o,
   output logic                     pktValid_o,
   output logic                     locked_o,
   output logic                     frameErr_o
);

   localparam int FRAME_BITS = NUM_CH * SLOT_BITS;
   localparam int PW         = $clog2(FRAME_BITS);
   localparam int LAST_BIT   = (NUM_CH - 1) * SLOT_BITS + WIDTH - 1;
   localparam int NSTG       = (NUM_CH > 1) ? NUM_CH - 1 : 1;

   typedef enum logic {S_HUNT = 1'b0, S_RUN = 1'b1} state_t;

   state_t                    r_state, w_state_nx;
   logic                      r_ws_q;
   logic [PW-1:0]             r_p, w_p_nx;
   logic [WIDTH-2:0]          r_shift;
   logic [WIDTH-1:0]          r_stage [NSTG];
   logic [NUM_CH*WIDTH-1:0]   r_data, w_pub;
   logic                      r_pkt, r_err;

   logic                      w_run, w_e, w_p_end, w_short, w_long;
   logic                      w_cap, w_shift_en, w_store, w_publish;
   logic [WIDTH-1:0]          w_word;
   int                        w_f, w_slot, w_sbit;

   assign w_run   = (r_state == S_RUN);
   assign w_e     = r_ws_q & ~ws_i;
   assign w_p_end = (r_p == PW'(FRAME_BITS - 1));
   assign w_short = w_run & w_e & ~w_p_end;
   assign w_long  = w_run & ~w_e & w_p_end;
   assign w_word  = {r_shift, sdata_i};

   always_ff @(posedge sclk_i) begin
      if (rst_i) r_state <= S_HUNT;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_p_nx     = '0;
      case (r_state)
         S_HUNT: if (w_e) w_state_nx = S_RUN;
         S_RUN: begin
            if (w_long)    w_state_nx = S_HUNT;
            else if (!w_e) w_p_nx     = r_p + 1'b1;
         end
      endcase
   end

   // In I2S mode the bit sampled at the edge after period p is frame bit p, so the
   // last bit of a full-width frame lands on the next frame-start edge.
   always_comb begin
      w_cap = 1'b0;
      w_f   = 0;
      if (MODE == 0) begin
         w_cap = w_run & ~w_long;
         w_f   = int'(r_p);
      end else begin
         w_cap = w_e | (w_run & ~w_long);
         w_f   = w_e ? 0 : int'(r_p) + 1;
      end
      w_slot     = w_f / SLOT_BITS;
      w_sbit     = w_f % SLOT_BITS;
      w_shift_en = w_cap && (w_sbit < WIDTH);
      w_store    = w_shift_en && (w_sbit == WIDTH - 1);
      w_publish  = w_store && (w_f == LAST_BIT) && !w_short;
   end

   always_comb begin
      w_pub = '0;
      for (int k = 0; k < NUM_CH - 1; k++) w_pub[k*WIDTH +: WIDTH] = r_stage[k];
      w_pub[(NUM_CH-1)*WIDTH +: WIDTH] = w_word;
   end

   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         r_ws_q  <= 1'b0;
         r_p     <= '0;
         r_shift <= '0;
         for (int k = 0; k < NSTG; k++) r_stage[k] <= '0;
         r_data  <= '0;
         r_pkt   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ws_q <= ws_i;
         r_p    <= w_p_nx;
         if (w_shift_en) r_shift <= w_word[WIDTH-2:0];
         for (int k = 0; k < NSTG; k++) begin
            if (w_short || w_long)
               r_stage[k] <= '0;
            else if (w_store && (w_slot == k) && (k < NUM_CH - 1))
               r_stage[k] <= w_word;
         end
         r_pkt <= w_publish;
         if (w_publish) r_data <= w_pub;
         // A new framing error outranks a clear request on the same edge.
         if (w_short || w_long) r_err <= 1'b1;
         else if (clrErr_i)     r_err <= 1'b0;
      end
   end

   assign chanData_o = r_data;
   assign pktValid_o = r_pkt;
   assign locked_o   = w_run;
   assign frameErr_o = r_err;

endmodule
